// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data_ram signal bundle for lsu_mem_ctrl.
// slave  : controller view (takes requests, drives the RAM).
// master : MEM stage + data_ram view.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
    output req_ready, resp_valid, resp_rdata, resp_fault, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_fault, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller for a single-port, word-wide data_ram.
// Sub-word stores are done as read-modify-write since the RAM only has a
// whole-word write enable. Optional macro MISALIGN_TRAP_EN: when defined,
// misaligned halfword/word accesses fault instead of being force-aligned.
module lsu_mem_ctrl #(
  parameter int RAM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input logic          clk,
  input logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_WR, RESP} state_t;

  localparam logic [1:0] LAT = RAM_RD_LAT[1:0];

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [15:0]       wd_q;
  logic [1:0]        rd_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [31:0]       rdata_q;
  logic              fault_q;

  logic              accept, rd_last, illegal, misalign, fault, is_sw;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ld_val, rmw_val;

  // Ready is only true in IDLE out of reset, so reset always beats a request.
  assign accept  = bus.req_valid & rst_n & (state == IDLE);
  assign rd_last = (rd_cnt == LAT);
  assign is_sw   = bus.req_we & (bus.req_funct3 == 3'b010);

  assign illegal = bus.req_we ? (bus.req_funct3 > 3'b010)
                 : !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef MISALIGN_TRAP_EN
  assign misalign = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                    ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
`else
  // Halfword uses only addr[1], word ignores addr[1:0]: natural alignment.
  assign misalign = 1'b0;
`endif
  assign fault = illegal | misalign;

  // Lane extraction and merge from the word returned by the RAM.
  always_comb begin
    byte_v  = bus.ram_dout[{off_q, 3'b000} +: 8];
    half_v  = off_q[1] ? bus.ram_dout[31:16] : bus.ram_dout[15:0];
    ld_val  = bus.ram_dout;
    rmw_val = bus.ram_dout;
    case (f3_q)
      3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_val = {{16{half_v[15]}}, half_v};
      3'b100:  ld_val = {24'd0, byte_v};
      3'b101:  ld_val = {16'd0, half_v};
      default: ld_val = bus.ram_dout;
    endcase
    if (f3_q[1:0] == 2'b00) rmw_val[{off_q, 3'b000} +: 8] = wd_q[7:0];
    else                    rmw_val[{off_q[1], 4'b0000} +: 16] = wd_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded handshake/strobe outputs.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.ram_we     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = rst_n;
        if (accept) begin
          if (fault)      state_nxt = RESP;
          else if (is_sw) state_nxt = WR;
          else            state_nxt = RD;
        end
      end
      RD:      if (rd_last) state_nxt = we_q ? RMW_WR : RESP;
      WR: begin
        bus.ram_we = rst_n;
        state_nxt  = RESP;
      end
      RMW_WR: begin
        bus.ram_we = rst_n;
        state_nxt  = RESP;
      end
      RESP: begin
        bus.resp_valid = rst_n;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, read-latency count, load result and RAM write data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      wd_q    <= 16'd0;
      rd_cnt  <= 2'd0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        off_q   <= bus.req_addr[1:0];
        wd_q    <= bus.req_wdata[15:0];
        rd_cnt  <= 2'd0;
        addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        rdata_q <= 32'd0;
        fault_q <= fault;
        if (is_sw && !fault) din_q <= bus.req_wdata;
      end
      if (state == RD) begin
        rd_cnt <= rd_cnt + 2'd1;
        if (rd_last) begin
          if (we_q) din_q   <= rmw_val;
          else      rdata_q <= ld_val;
        end
      end
    end
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_din    = din_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: three instances (RAM_RD_LAT 1, 0, 3) each with a
// behavioural data_ram. Expected responses go into a queue at issue time and
// are popped when resp_valid shows up.
module tb_lsu_mem_ctrl;
  function automatic int latof(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  logic        rv   [3];
  logic        rwe_i[3];
  logic [2:0]  f3   [3];
  logic [31:0] ad   [3];
  logic [31:0] wd   [3];
  logic        rdy  [3];
  logic        rvld [3];
  logic [31:0] rdat [3];
  logic        rflt [3];
  logic        rwe  [3];
  logic [31:0] raddr[3];
  logic [31:0] rdin [3];
  int          wecnt[3];
  logic [31:0] wr_a [3];
  logic [31:0] wr_d [3];
  int          wr_c [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = latof(g);
    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();
    logic [31:0] mem  [0:63];
    logic [31:0] pipe [0:3];
    int          cnt = 0;
    logic [31:0] la, ld;
    int          lc;

    assign bus.req_valid  = rv[g];
    assign bus.req_we     = rwe_i[g];
    assign bus.req_funct3 = f3[g];
    assign bus.req_addr   = ad[g];
    assign bus.req_wdata  = wd[g];
    assign rdy[g]   = bus.req_ready;
    assign rvld[g]  = bus.resp_valid;
    assign rdat[g]  = bus.resp_rdata;
    assign rflt[g]  = bus.resp_fault;
    assign rwe[g]   = bus.ram_we;
    assign raddr[g] = bus.ram_addr;
    assign rdin[g]  = bus.ram_din;
    assign wecnt[g] = cnt;
    assign wr_a[g]  = la;
    assign wr_d[g]  = ld;
    assign wr_c[g]  = lc;

    // data_ram model: word write, read data delayed by L clocks.
    always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr[7:2]] <= bus.ram_din;
      pipe[0] <= mem[bus.ram_addr[7:2]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
    if (L == 0) begin : g_l0
      assign bus.ram_dout = mem[bus.ram_addr[7:2]];
    end else begin : g_lp
      assign bus.ram_dout = pipe[L-1];
    end

    // Record every write strobe seen mid-cycle.
    always @(negedge clk) begin
      if (bus.ram_we) begin
        cnt <= cnt + 1;
        la  <= bus.ram_addr;
        ld  <= bus.ram_din;
        lc  <= cyc;
      end
    end

    lsu_mem_ctrl #(.RAM_RD_LAT(L), .ADDR_W(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Hold request until accepted; acc = edge number of acceptance.
  task automatic wait_acc(input int k, output int acc);
    bit got = 0;
    acc = cyc;
    for (int t = 0; t < 20; t++) begin
      if (rdy[k]) begin
        @(negedge clk);
        acc = cyc - 1;
        got = 1;
        break;
      end
      @(negedge clk);
    end
    rv[k] = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  // Wait for the response, pop the scoreboard, compare data/fault/latency.
  task automatic wait_resp(input int k, input int acc);
    bit   got = 0;
    exp_t e;
    for (int t = 0; t < 20; t++) begin
      if (rvld[k]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got || sbq.size() == 0) begin
      chk("resp_timeout", {31'd0, got}, 1);
    end else begin
      e = sbq.pop_front();
      chk("rdata", rdat[k], e.rdata);
      chk("fault", {31'd0, rflt[k]}, {31'd0, e.fault});
      chk("resp_lat", cyc - acc, e.lat);
      @(negedge clk);
      chk("resp_one_cycle", {31'd0, rvld[k]}, 0);
    end
  endtask

  task automatic drive(input int k, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    rv[k] = 1'b1; rwe_i[k] = w; f3[k] = f; ad[k] = a; wd[k] = d;
  endtask

  task automatic do_op(input int k, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ef,
                       input int elat, input int nwr, input logic [31:0] ewd, input int wlat);
    int   acc;
    int   c0 = wecnt[k];
    exp_t e;
    e.rdata = er; e.fault = ef; e.lat = elat;
    sbq.push_back(e);
    drive(k, w, f, a, d);
    wait_acc(k, acc);
    wait_resp(k, acc);
    chk("ram_we_count", wecnt[k] - c0, nwr);
    if (nwr > 0) begin
      chk("ram_addr", wr_a[k], {a[31:2], 2'b00});
      chk("ram_din", wr_d[k], ewd);
      chk("ram_we_cycle", wr_c[k] - acc, wlat);
    end
  endtask

  initial begin
    int a1, a2, c0, L;
    bit seen;
    exp_t e;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0; rwe_i[k] = 1'b0; f3[k] = 3'd0; ad[k] = 32'd0; wd[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'd0, rdy[k]}, 0);
      chk("rst_resp_valid", {31'd0, rvld[k]}, 0);
      chk("rst_ram_we", {31'd0, rwe[k]}, 0);
      chk("rst_ram_addr", raddr[k], 0);
      chk("rst_ram_din", rdin[k], 0);
      chk("rst_rdata", rdat[k], 0);
      chk("rst_fault", {31'd0, rflt[k]}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, rdy[0]}, 1);

    L = latof(0);
    // SW then LW
    do_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 2, 1, 32'hDEADBEEF, 1);
    do_op(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, L + 2, 0, 0, 0);
    // SB read-modify-write and byte loads
    do_op(0, 1, 3'b010, 32'h20, 32'hCAFEBABE, 0, 0, 2, 1, 32'hCAFEBABE, 1);
    do_op(0, 1, 3'b000, 32'h21, 32'hAAAAAA55, 0, 0, L + 3, 1, 32'hCAFE55BE, L + 2);
    do_op(0, 0, 3'b000, 32'h21, 32'h0, 32'h00000055, 0, L + 2, 0, 0, 0);
    do_op(0, 0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFCA, 0, L + 2, 0, 0, 0);
    do_op(0, 0, 3'b100, 32'h23, 32'h0, 32'h000000CA, 0, L + 2, 0, 0, 0);
    // SH read-modify-write and halfword loads
    do_op(0, 1, 3'b010, 32'h20, 32'h11223344, 0, 0, 2, 1, 32'h11223344, 1);
    do_op(0, 1, 3'b001, 32'h22, 32'h55558001, 0, 0, L + 3, 1, 32'h80013344, L + 2);
    do_op(0, 0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 0, L + 2, 0, 0, 0);
    do_op(0, 0, 3'b101, 32'h22, 32'h0, 32'h00008001, 0, L + 2, 0, 0, 0);
    do_op(0, 0, 3'b001, 32'h20, 32'h0, 32'h00003344, 0, L + 2, 0, 0, 0);
    // illegal funct3: load 011, store 100
    do_op(0, 0, 3'b011, 32'h10, 32'h0, 0, 1, 1, 0, 0, 0);
    do_op(0, 1, 3'b100, 32'h10, 32'h12345678, 0, 1, 1, 0, 0, 0);
    do_op(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, L + 2, 0, 0, 0);
    // misaligned word
`ifdef MISALIGN_TRAP_EN
    do_op(0, 0, 3'b010, 32'h12, 32'h0, 0, 1, 1, 0, 0, 0);
`else
    do_op(0, 0, 3'b010, 32'h12, 32'h0, 32'hDEADBEEF, 0, L + 2, 0, 0, 0);
`endif

    // reset while an SB is in its read phase
    do_op(0, 1, 3'b010, 32'h28, 32'h01020304, 0, 0, 2, 1, 32'h01020304, 1);
    c0 = wecnt[0];
    drive(0, 1, 3'b000, 32'h28, 32'h000000FF);
    wait_acc(0, a1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, rdy[0]}, 0);
    chk("midrst_resp_valid", {31'd0, rvld[0]}, 0);
    chk("midrst_ram_addr", raddr[0], 0);
    chk("midrst_ram_din", rdin[0], 0);
    chk("midrst_rdata", rdat[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", {31'd0, rdy[0]}, 1);
    repeat (4) @(negedge clk);
    chk("midrst_no_write", wecnt[0] - c0, 0);
    chk("midrst_no_resp", sbq.size(), 0);
    do_op(0, 0, 3'b010, 32'h28, 32'h0, 32'h01020304, 0, L + 2, 0, 0, 0);

    // back-to-back SW then LW with req_valid held, all three latencies
    for (int k = 0; k < 3; k++) begin
      L = latof(k);
      e.rdata = 0; e.fault = 0; e.lat = 2;
      sbq.push_back(e);
      e.rdata = 32'h5A5A0000 + k; e.fault = 0; e.lat = L + 2;
      sbq.push_back(e);
      drive(k, 1, 3'b010, 32'h30, 32'h5A5A0000 + k);
      wait_acc(k, a1);
      drive(k, 0, 3'b010, 32'h30, 32'h0);
      seen = 0;
      for (int t = 0; t < 10; t++) begin
        if (rvld[k]) begin
          e = sbq.pop_front();
          chk("b2b_sw_lat", cyc - a1, e.lat);
          seen = 1;
        end
        if (rdy[k]) break;
        @(negedge clk);
      end
      chk("b2b_sw_resp", {31'd0, seen}, 1);
      wait_acc(k, a2);
      chk("b2b_accept_gap", a2 - a1, 3);
      wait_resp(k, a2);
    end

    // sub-word stores at the other latencies
    do_op(1, 1, 3'b010, 32'h40, 32'h11111111, 0, 0, 2, 1, 32'h11111111, 1);
    do_op(1, 1, 3'b001, 32'h40, 32'h0000FFEE, 0, 0, 3, 1, 32'h1111FFEE, 2);
    do_op(1, 0, 3'b001, 32'h40, 32'h0, 32'hFFFFFFEE, 0, 2, 0, 0, 0);
    do_op(2, 1, 3'b010, 32'h40, 32'hA1B2C3D4, 0, 0, 2, 1, 32'hA1B2C3D4, 1);
    do_op(2, 1, 3'b000, 32'h43, 32'h0000007F, 0, 0, 6, 1, 32'h7FB2C3D4, 5);
    do_op(2, 0, 3'b000, 32'h43, 32'h0, 32'h0000007F, 0, 5, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
